outport_hex_display: RTL and testbench
======================================

Name: outport_hex_display

Overview:
- Consumer at the far end of the CPU outport: captures each 32-bit value the datapath writes to its outport and shows it as 8 hex digits on time-multiplexed, common-anode seven-segment displays.
- Double-buffered, so a new value appears only at a frame boundary and a frame never mixes digits from two values.
- Sits at board top level, between the datapath's outport output/enable and the display pins.

Parameters:
- CLK_DIV, 4, clk cycles each digit stays lit; must be ≥2.
- NUM_DIGITS, 8, digits scanned; must be 8, since the 32-bit word gives one nibble per digit.

Ports:
- clk  input  1  system clock, same as datapath.
- clr  input  1  asynchronous, active-high reset.
- outport_Data  input  32  value currently held in the outport register.
- outport_write  input  1  one-cycle strobe; high in the cycle the outport register loads.
- anode_n  output  NUM_DIGITS  active-low digit select; one-hot-low while scanning.
- seg_n  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- frame_done  output  1  one-cycle pulse after the last digit period of each frame.
- pending  output  1  high while a captured value waits for the next frame boundary.

Behaviour:
- Reset (clr high, asynchronous):
  - State IDLE.
  - anode_n = all 1s, seg_n = 7'h7F, frame_done = 0, pending = 0.
  - Shadow and display registers = 0; div and digit counters = 0.
  - Clr asserted mid-frame blanks the display immediately. Any pending value is lost.
- Capture:
  - On a clk edge with outport_write = 1, shadow <= outport_Data and pending <= 1.
  - Back-to-back writes: the last write wins.
  - Capture happens at the same edge whatever the state is.
- States:
  - IDLE: display blanked. On an edge where pending = 1: display <= shadow, pending <= 0, digit <= 0, div <= 0, go to SCAN.
  - SCAN: div counts 0..CLK_DIV-1.
    - At div = CLK_DIV-1: div <= 0 and digit advances.
    - At digit = NUM_DIGITS-1 with div = CLK_DIV-1 (frame boundary): digit <= 0 and frame_done pulses high for the next cycle.
    - At a frame boundary with pending = 1: display <= shadow and pending <= 0 at that same edge.
    - If outport_write coincides with the boundary edge, shadow captures the new value and pending stays 1. The display loads the previous shadow content; the new value shows next frame.
- Scan output (registered; all outputs are registered):
  - Digit d (0 = least significant nibble, display[3:0]) drives anode_n[d] = 0 and seg_n = hex pattern of display[4d+3:4d].
  - Hex patterns (seg_n):
    - 0 = 40, 1 = 79, 2 = 24, 3 = 30
    - 4 = 19, 5 = 12, 6 = 02, 7 = 78
    - 8 = 00, 9 = 10, A = 08, b = 03
    - C = 46, d = 21, E = 06, F = 0E
- Latency:
  - First write after reset: state is SCAN one edge after the capture edge.
  - anode_n[0] goes low and seg_n is valid one cycle after entering SCAN, because outputs are registered.
- Frame length = NUM_DIGITS × CLK_DIV cycles.
- There is no path back to IDLE except clr.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: while scanning, any digit above the most significant non-zero nibble of display outputs seg_n = 7F, and its anode is still driven.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Undefined: all 8 digits always show their nibble, including leading zeros.

Test Plan:
- Reset → anode_n = FF, seg_n = 7F, pending = 0. Hold 100 cycles with no write → outputs unchanged.
- Write 32'h89ABCDEF, CLK_DIV = 4 → digit 0 shows seg_n = 0E (F) for 4 cycles, then digit 1 shows 21 (d), and so on to digit 7 showing 00 (8). frame_done pulses once every 32 cycles.
- Mid-frame write of 32'h00000001 during digit 3 → pending = 1 until the frame boundary. The rest of the frame still shows the old value; the next frame shows digit 0 = 79 and other digits = 40 (or 7F with LEADING_ZERO_BLANK_EN).
- Writes of 1, then 2, then 3 on consecutive cycles within one frame → the next frame shows only value 3.
- Write coinciding with the frame-boundary edge → the display switches to the earlier pending value, pending stays 1, and the new value appears the frame after.
- Assert clr during digit 5 → anode_n = FF and seg_n = 7F immediately, without waiting for a clk edge. After release → IDLE until the next write.

Source files
------------

// File: rtl/outport_hex_display.sv
// outport_hex_display: double-buffered 8-digit hex viewer for the CPU outport, scanned on common-anode 7-seg displays.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero nibble.
module outport_hex_display #(
    parameter int CLK_DIV    = 4,
    parameter int NUM_DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [31:0]           outport_Data,
    input  logic                  outport_write,
    output logic [NUM_DIGITS-1:0] anode_n,
    output logic [6:0]            seg_n,
    output logic                  frame_done,
    output logic                  pending
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = $clog2(NUM_DIGITS);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                state_q, state_d;
    logic [31:0]           shadow_q, shadow_d, disp_q, disp_d;
    logic                  pend_q, pend_d, fdone_q, fdone_d;
    logic [DW-1:0]         div_q, div_d;
    logic [GW-1:0]         dig_q, dig_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [6:0]            seg_q, seg_d;
    logic                  last_div, boundary;
    logic [3:0]            nib;
`ifdef LEADING_ZERO_BLANK_EN
    logic [GW-1:0]         msd;
`endif

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        disp_d   = disp_q;
        pend_d   = pend_q;
        div_d    = div_q;
        dig_d    = dig_q;
        shadow_d = outport_write ? outport_Data : shadow_q;
        last_div = div_q == DW'(CLK_DIV - 1);
        boundary = last_div && dig_q == GW'(NUM_DIGITS - 1);
        nib      = disp_q[{dig_q, 2'b00} +: 4];
        if (state_q == IDLE) begin
            if (pend_q) begin
                disp_d  = shadow_q;
                pend_d  = 1'b0;
                div_d   = '0;
                dig_d   = '0;
                state_d = SCAN;
            end
        end else begin
            div_d = last_div ? '0 : div_q + DW'(1);
            dig_d = boundary ? '0 : (last_div ? dig_q + GW'(1) : dig_q);
            if (boundary && pend_q) begin
                disp_d = shadow_q;
                pend_d = 1'b0;
            end
        end
        // a write on the load edge re-arms pending: the new value shows a frame later
        if (outport_write) pend_d = 1'b1;
        fdone_d = state_q == SCAN && boundary;
        anode_d = state_q == SCAN ? ~(NUM_DIGITS'(1) << dig_q) : '1;
        seg_d   = state_q == SCAN ? hex7(nib) : 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
        msd = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (disp_q[4*i +: 4] != 4'h0) msd = GW'(i);
        if (dig_q > msd) seg_d = 7'h7F;
`endif
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            disp_q   <= '0;
            pend_q   <= 1'b0;
            div_q    <= '0;
            dig_q    <= '0;
            fdone_q  <= 1'b0;
            anode_q  <= '1;
            seg_q    <= 7'h7F;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            pend_q   <= pend_d;
            div_q    <= div_d;
            dig_q    <= dig_d;
            fdone_q  <= fdone_d;
            anode_q  <= anode_d;
            seg_q    <= seg_d;
        end
    end

    assign anode_n    = anode_q;
    assign seg_n      = seg_q;
    assign frame_done = fdone_q;
    assign pending    = pend_q;
endmodule

// File: tb/tb_outport_hex_display.sv
// tb_outport_hex_display: random and directed outport writes checked against a frame-time reference model.
module tb_outport_hex_display;
    localparam int CD = 4;
    localparam int ND = 8;
    localparam int FL = CD * ND;

    logic        clk = 1'b0, clr = 1'b1, wr = 1'b0;
    logic [31:0] data = '0;
    logic [7:0]  anode_n;
    logic [6:0]  seg_n;
    logic        frame_done, pending;

    outport_hex_display #(.CLK_DIV(CD), .NUM_DIGITS(ND)) dut (
        .clk(clk), .clr(clr), .outport_Data(data), .outport_write(wr),
        .anode_n(anode_n), .seg_n(seg_n), .frame_done(frame_done), .pending(pending)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // reference: scanning time t counts edges since the display went live
    bit          m_scan, m_pend, e_fd;
    int          m_t;
    logic [31:0] m_sh, m_disp;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [31:0] v, input int d);
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && (v >> (4 * d)) == 0) return 7'h7F;
`endif
        return hex_tab[(v >> (4 * d)) & 32'hF];
    endfunction

    task automatic model_reset();
        m_scan = 0; m_pend = 0; m_t = 0; m_sh = 0; m_disp = 0;
        e_an = 8'hFF; e_seg = 7'h7F; e_fd = 0;
    endtask

    task automatic model_edge(input bit w, input logic [31:0] dv);
        int d;
        if (clr) begin
            model_reset();
            return;
        end
        d     = (m_t / CD) % ND;
        e_an  = m_scan ? ~(8'd1 << d) : 8'hFF;
        e_seg = m_scan ? seg_of(m_disp, d) : 7'h7F;
        e_fd  = m_scan && (m_t % FL == FL - 1);
        if (!m_scan) begin
            if (m_pend) begin
                m_disp = m_sh; m_pend = 0; m_scan = 1; m_t = 0;
            end
        end else begin
            if (m_t % FL == FL - 1 && m_pend) begin
                m_disp = m_sh; m_pend = 0;
            end
            m_t++;
        end
        if (w) begin
            m_sh = dv; m_pend = 1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".anode"}, 32'(anode_n), 32'(e_an));
        check({tag, ".seg"}, 32'(seg_n), 32'(e_seg));
        check({tag, ".fdone"}, 32'(frame_done), 32'(e_fd));
        check({tag, ".pend"}, 32'(pending), 32'(m_pend));
    endtask

    task automatic cyc(input bit w, input logic [31:0] dv, input string tag);
        wr = w; data = dv;
        @(posedge clk);
        model_edge(w, dv);
        #1;
        wr = 0;
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(0, 0, tag);
    endtask

    function automatic bit at_digit(input int d);
        return m_scan && ((m_t % FL) / CD == d) && (m_t % CD == 0);
    endfunction

    task automatic wait_digit(input int d, input string tag);
        int n = 0;
        while (!at_digit(d) && n < 200) begin cyc(0, 0, tag); n++; end
        check({tag, ".reach"}, 32'(at_digit(d)), 32'd1);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        clr = 0;
        idle(100, "idle");
        cyc(1, 32'h89ABCDEF, "wr0");
        idle(80, "frame0");
        wait_digit(3, "mid");
        cyc(1, 32'h00000001, "midwr");
        check("mid_pend", 32'(pending), 32'd1);
        idle(70, "mid_after");
        wait_digit(2, "b2b");
        cyc(1, 1, "b2b1"); cyc(1, 2, "b2b2"); cyc(1, 3, "b2b3");
        idle(70, "b2b_after");
        wait_digit(1, "bnd");
        cyc(1, 32'hA5A50F00, "bnd_pre");
        for (int i = 0; i < 200 && !(m_scan && m_t % FL == FL - 1); i++) cyc(0, 0, "bnd_wait");
        cyc(1, 32'h12345678, "bnd_wr");
        check("bnd_disp", m_disp, 32'hA5A50F00);
        check("bnd_pend", 32'(pending), 32'd1);
        idle(70, "bnd_after");
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] v;
            v = $urandom() >> $urandom_range(0, 31);
            cyc($urandom_range(0, 19) == 0, v, "rand");
        end
        wait_digit(5, "clr");
        #2 clr = 1;
        #1;
        check("clr_anode", 32'(anode_n), 32'hFF);
        check("clr_seg", 32'(seg_n), 32'h7F);
        check("clr_pend", 32'(pending), 32'd0);
        cyc(1, 32'hDEADBEEF, "clr_held");
        cyc(0, 0, "clr_held");
        clr = 0;
        idle(20, "post_clr");
        cyc(1, 32'h0000C0DE, "wr_post");
        idle(40, "post_frame");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
